// File: rtl/btc_block_feeder_if.sv
// Message-word stream from the block feeder to the SHA-256 compression cores.
// A beat transfers on any cycle where blk_valid and blk_ready are both high.
interface btc_block_feeder_if;
    logic        blk_valid;
    logic        blk_ready;
    logic [31:0] blk_word;
    logic [3:0]  blk_idx;
    logic        blk_sel;
    logic [31:0] blk_nonce;
    logic        blk_last;

    modport master (
        output blk_valid, blk_word, blk_idx, blk_sel, blk_nonce, blk_last,
        input  blk_ready
    );

    modport slave (
        input  blk_valid, blk_word, blk_idx, blk_sel, blk_nonce, blk_last,
        output blk_ready
    );
endinterface

// File: rtl/btc_block_feeder.sv
// Fetches a 20-word block header, then streams message block 1 once followed by
// one padded message block 2 per nonce on a valid/ready word stream.
module btc_block_feeder #(
    parameter int NUM_NONCES = 16,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] header_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    input  logic [31:0]       mem_rd_data,
    btc_block_feeder_if.master blk,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, FETCH, SEND_B1, SEND_B2, FIN} state_t;

    state_t            state;
    state_t            next_state;
    logic [4:0]        fetch_cnt;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       hdr [20];
    logic [3:0]        idx;
    logic              sel;
    logic [31:0]       nonce;
    logic              valid_q;
    logic [31:0]       word;
    logic              fire;
    logic              block_end;
    logic              final_beat;

    assign fire       = valid_q && blk.blk_ready;
    assign block_end  = fire && (idx == 4'd15);
    assign final_beat = block_end && sel && (nonce == 32'(NUM_NONCES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = FETCH;
            FETCH:   if (fetch_cnt == 5'd20) next_state = SEND_B1;
            SEND_B1: if (block_end) next_state = SEND_B2;
            SEND_B2: if (final_beat) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Fetch issues one address per cycle and captures each word a cycle later,
    // so capture trails the address counter by one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt <= '0;
            base_addr <= '0;
            mem_addr  <= '0;
            idx       <= '0;
            sel       <= 1'b0;
            nonce     <= '0;
            valid_q   <= 1'b0;
            for (int k = 0; k < 20; k++) hdr[k] <= '0;
        end else begin
            valid_q <= (next_state == SEND_B1) || (next_state == SEND_B2);
            case (state)
                IDLE: begin
                    if (start) begin
                        base_addr <= header_addr;
                        mem_addr  <= header_addr;
                        fetch_cnt <= '0;
                        idx       <= '0;
                        sel       <= 1'b0;
                        nonce     <= '0;
                    end
                end
                FETCH: begin
                    fetch_cnt <= fetch_cnt + 5'd1;
                    if (fetch_cnt != 5'd0) hdr[fetch_cnt - 5'd1] <= mem_rd_data;
                    if (fetch_cnt < 5'd19) mem_addr <= base_addr + ADDR_W'(fetch_cnt) + ADDR_W'(1);
                end
                SEND_B1, SEND_B2: begin
                    if (fire) begin
                        idx <= idx + 4'd1;
                        if (final_beat) begin
                            sel   <= 1'b0;
                            nonce <= '0;
                        end else if (block_end) begin
                            if (sel) nonce <= nonce + 32'd1;
                            else     sel   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Block 2 is the header tail with the nonce spliced in, then fixed SHA-256
    // padding for a 640-bit message.
    always_comb begin
        word = '0;
        if (!sel) begin
            word = hdr[{1'b0, idx}];
        end else begin
            case (idx)
                4'd0:    word = hdr[16];
                4'd1:    word = hdr[17];
                4'd2:    word = hdr[18];
                4'd3:    word = nonce;
                4'd4:    word = 32'h8000_0000;
                4'd15:   word = 32'd640;
                default: word = '0;
            endcase
        end
    end

    assign blk.blk_valid = valid_q;
    assign blk.blk_word  = word;
    assign blk.blk_idx   = idx;
    assign blk.blk_sel   = sel;
    assign blk.blk_nonce = sel ? nonce : 32'd0;
    assign blk.blk_last  = valid_q && (idx == 4'd15);

    assign mem_we = 1'b0;
    assign busy   = (state == FETCH) || (state == SEND_B1) || (state == SEND_B2);
    assign done   = (state == FIN);
endmodule

// File: tb/tb_btc_block_feeder.sv
// Self-checking bench for btc_block_feeder: fixed vectors for the smoke job plus
// randomized jobs compared against a block-stream model built from memory contents.
module tb_btc_block_feeder;
    localparam int NUM_NONCES = 16;
    localparam int ADDR_W     = 16;
    localparam int TOTAL      = 16 * (1 + NUM_NONCES);

    typedef struct packed {
        logic [31:0] word;
        logic [3:0]  idx;
        logic        sel;
        logic [31:0] nonce;
        logic        last;
    } beat_t;

    typedef struct {
        int    beat;
        beat_t exp;
    } vec_t;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] header_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_rd_data;
    logic              busy;
    logic              done;

    btc_block_feeder_if bus();

    btc_block_feeder #(.NUM_NONCES(NUM_NONCES), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .header_addr (header_addr),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_rd_data (mem_rd_data),
        .blk         (bus),
        .busy        (busy),
        .done        (done)
    );

    logic [31:0]       mem [65536];
    int                checks;
    int                errors;
    beat_t             cap_q[$];
    beat_t             exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int                fetch_cycles;
    int                done_count;
    bit                rand_ready;
    bit                prev_stall;
    bit                prev_xfer;
    beat_t             prev_beat;
    beat_t             mon_beat;
    vec_t              tbl[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_rd_data <= mem[mem_addr];

    initial begin
        bus.blk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.blk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic beat_t mk(input logic [31:0] w, input int i, input logic s, input logic [31:0] n, input logic l);
        beat_t b;
        b.word = w; b.idx = 4'(i); b.sel = s; b.nonce = n; b.last = l;
        return b;
    endfunction

    function automatic beat_t cur_beat();
        return mk(bus.blk_word, int'(bus.blk_idx), bus.blk_sel, bus.blk_nonce, bus.blk_last);
    endfunction

    // Expected stream: block 1 is header words 0..15, then per nonce the header
    // tail, the nonce, the 0x80 pad bit, zeros and the 640-bit length.
    function automatic void build_model(input logic [ADDR_W-1:0] addr);
        logic [31:0] h [20];
        logic [31:0] w;
        exp_q.delete();
        for (int k = 0; k < 20; k++) h[k] = mem[ADDR_W'(addr + ADDR_W'(k))];
        for (int b = 0; b <= NUM_NONCES; b++) begin
            for (int i = 0; i < 16; i++) begin
                if (b == 0)       w = h[i];
                else if (i < 3)   w = h[16 + i];
                else if (i == 3)  w = 32'(b - 1);
                else if (i == 4)  w = 32'h8000_0000;
                else if (i == 15) w = 32'd640;
                else              w = 32'd0;
                exp_q.push_back(mk(w, i, b != 0, (b == 0) ? 32'd0 : 32'(b - 1), i == 15));
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
            prev_xfer  = 1'b0;
        end else begin
            mon_beat = cur_beat();
            if (prev_stall) begin
                checkOutput("stall_valid", bus.blk_valid, 1);
                checkOutput("stall_hold", mon_beat, prev_beat);
            end
            if (busy && !bus.blk_valid) begin
                fetch_cycles++;
                addr_q.push_back(mem_addr);
            end
            if (done) begin
                done_count++;
                checkOutput("busy_at_done", busy, 0);
                checkOutput("done_timing", {prev_xfer, cap_q.size() == TOTAL}, 2'b11);
            end
            prev_xfer = bus.blk_valid && bus.blk_ready;
            if (prev_xfer) cap_q.push_back(mon_beat);
            prev_stall = bus.blk_valid && !bus.blk_ready;
            prev_beat  = mon_beat;
        end
    end

    task automatic clear_capture();
        cap_q.delete();
        addr_q.delete();
        fetch_cycles = 0;
        done_count   = 0;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] addr);
        @(negedge clk);
        start       = 1'b1;
        header_addr = addr;
        @(negedge clk);
        start       = 1'b0;
        header_addr = ADDR_W'($urandom);
    endtask

    task automatic fill_random(input logic [ADDR_W-1:0] addr);
        for (int k = 0; k < 20; k++) mem[ADDR_W'(addr + ADDR_W'(k))] = $urandom;
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input bit rnd, input int mid_start_beat);
        int cyc;
        bit mid_done;
        build_model(addr);
        clear_capture();
        rand_ready = rnd;
        pulse_start(addr);
        cyc      = 0;
        mid_done = 1'b0;
        while (done_count == 0 && cyc < 5000) begin
            if (!mid_done && mid_start_beat >= 0 && cap_q.size() >= mid_start_beat) begin
                start       = 1'b1;
                header_addr = addr ^ 16'h0F0F;
                mid_done    = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end else begin
                @(negedge clk);
            end
            cyc++;
        end
        checkOutput("done_seen", done_count != 0, 1);
        repeat (3) @(negedge clk);
        checkOutput("done_once", done_count, 1);
        checkOutput("fetch_cycles", fetch_cycles, 21);
        checkOutput("fetch_addr_count", addr_q.size(), 21);
        for (int k = 0; k < 20 && k < addr_q.size(); k++)
            checkOutput($sformatf("fetch_addr%0d", k), addr_q[k], ADDR_W'(addr + ADDR_W'(k)));
        checkOutput("beat_count", cap_q.size(), TOTAL);
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            checkOutput($sformatf("beat%0d", i), cap_q[i], exp_q[i]);
    endtask

    initial begin
        logic [31:0] n5_words [16];
        int cyc;
        checks      = 0;
        errors      = 0;
        rand_ready  = 1'b0;
        reset_n     = 1'b0;
        start       = 1'b0;
        header_addr = '0;
        clear_capture();

        n5_words = '{32'hA000_0010, 32'hA000_0011, 32'hA000_0012, 32'h0000_0005,
                     32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0280};
        tbl.push_back('{beat: 0,   exp: mk(32'hA000_0000, 0,  1'b0, 32'd0,  1'b0)});
        tbl.push_back('{beat: 15,  exp: mk(32'hA000_000F, 15, 1'b0, 32'd0,  1'b1)});
        tbl.push_back('{beat: 16,  exp: mk(32'hA000_0010, 0,  1'b1, 32'd0,  1'b0)});
        tbl.push_back('{beat: 271, exp: mk(32'h0000_0280, 15, 1'b1, 32'd15, 1'b1)});
        for (int i = 0; i < 16; i++)
            tbl.push_back('{beat: 96 + i, exp: mk(n5_words[i], i, 1'b1, 32'd5, i == 15)});

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    {bus.blk_valid, bus.blk_word, bus.blk_idx, bus.blk_sel, bus.blk_nonce,
                     bus.blk_last, busy, done, mem_addr, mem_we}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] smoke job");
        for (int i = 0; i < 20; i++) mem[16'h0100 + i] = 32'hA000_0000 + 32'(i);
        applyStimulus(16'h0100, 1'b0, -1);
        foreach (tbl[t]) begin
            if (tbl[t].beat < cap_q.size())
                checkOutput($sformatf("vec_beat%0d", tbl[t].beat), cap_q[tbl[t].beat], tbl[t].exp);
            else
                checkOutput($sformatf("vec_beat%0d_present", tbl[t].beat), cap_q.size(), tbl[t].beat + 1);
        end
        checkOutput("mem_we", mem_we, 0);

        $display("[TB] backpressure job");
        applyStimulus(16'h0100, 1'b1, -1);

        $display("[TB] address wrap job");
        fill_random(16'hFFF8);
        applyStimulus(16'hFFF8, 1'b1, -1);

        $display("[TB] start pulsed mid-stream");
        fill_random(16'h0300);
        fill_random(16'h0300 ^ 16'h0F0F);
        applyStimulus(16'h0300, 1'b0, 50);

        for (int r = 0; r < 2; r++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'($urandom);
            $display("[TB] random job at %h", a);
            fill_random(a);
            applyStimulus(a, 1'b1, -1);
        end

        $display("[TB] reset mid-job");
        clear_capture();
        rand_ready = 1'b0;
        pulse_start(16'h0100);
        cyc = 0;
        while (cap_q.size() < 100 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("reached_beat100", cap_q.size() >= 100, 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("reset_async",
                    {bus.blk_valid, bus.blk_word, bus.blk_idx, bus.blk_sel, bus.blk_nonce,
                     bus.blk_last, busy, done, mem_addr}, 0);
        repeat (5) @(negedge clk);
        checkOutput("no_done_after_reset", done_count, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(16'h0100, 1'b1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
